// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite initiator behind a cmd/rsp valid-ready handshake.
// Optional watchdog enabled by defining AXIL_MST_TIMEOUT_EN (drives the sticky tmo_err flag).
module axil_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TMO_CYCLES = 1024
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_wr,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_rready,
    output logic [31:0]         wr_cnt,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         err_cnt,
    output logic                tmo_err
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("axil_cmd_master supports DATA_W = 32 only");
    end
    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("axil_cmd_master requires TMO_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    state_t                state, state_nxt;
    logic                  run_q;
    logic                  aw_done, w_done;
    logic                  wr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            resp_q;
    logic                  cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;

    // run_q keeps cmd_ready low during reset and for the first clock after release
    assign cmd_ready = (state == IDLE) && run_q;
    assign m_awvalid = (state == WR) && !aw_done;
    assign m_wvalid  = (state == WR) && !w_done;
    assign m_bready  = (state == WR_B);
    assign m_arvalid = (state == RD_A);
    assign m_rready  = (state == RD_R);
    assign rsp_valid = (state == RSP);

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_wr    = wr_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign aw_fire  = m_awvalid && m_awready;
    assign w_fire   = m_wvalid && m_wready;
    assign b_fire   = m_bvalid && m_bready;
    assign ar_fire  = m_arvalid && m_arready;
    assign r_fire   = m_rvalid && m_rready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_fire) state_nxt = cmd_wr ? WR : RD_A;
            // AW and W complete independently, possibly on the same edge
            WR:      if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_B;
            WR_B:    if (b_fire) state_nxt = RSP;
            RD_A:    if (ar_fire) state_nxt = RD_R;
            RD_R:    if (r_fire) state_nxt = RSP;
            RSP:     if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            run_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            run_q <= 1'b1;
            if (cmd_fire) begin
                wr_q    <= cmd_wr;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                rdata_q <= '0;
                resp_q  <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
            if (b_fire)  resp_q  <= m_bresp;
            if (r_fire) begin
                rdata_q <= m_rdata;
                resp_q  <= m_rresp;
            end
            if (rsp_fire) begin
                if (wr_q) wr_cnt <= wr_cnt + 32'd1;
                else      rd_cnt <= rd_cnt + 32'd1;
                if (resp_q != 2'b00) err_cnt <= err_cnt + 32'd1;
            end
        end
    end

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;
    logic             waiting;

    assign waiting = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);
    assign tmo_err = tmo_q;

    // Watch only; a stuck slave is flagged but the transaction keeps waiting
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (waiting && (tmo_cnt != TMO_W'(TMO_CYCLES))) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) tmo_q <= 1'b1;
        end
    end
`else
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed commands against a reactive register-model AXI-Lite slave,
// checked every cycle against a transaction-level response model plus literal expectations.
`timescale 1ns/1ps
module tb_axil_cmd_master;

    localparam int TMO = 16;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_wr;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] wr_cnt, rd_cnt, err_cnt;
    logic        tmo_err;

    always #5 clk_main_a0 = ~clk_main_a0;

    axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TMO_CYCLES(TMO)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt), .tmo_err(tmo_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // ---------------- reactive slave (drives on falling edges) ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
    bit          ar_block = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] smem [logic [31:0]];

    bit          aw_got, w_got, ar_got, s_aw, s_w, s_b, s_ar, s_r;
    int          aw_seen, w_seen, ar_seen, b_wait;
    logic [31:0] aw_a, w_d, ar_a, s_awaddr, s_wdata, s_araddr;
    logic [3:0]  w_s, s_wstrb;

    always @(negedge clk_main_a0) begin
        if (!rst_main_n) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
            m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = 0;
            s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
        end else begin
            // handshakes that completed on the rising edge just gone
            if (s_aw) begin aw_got = 1; aw_a = s_awaddr; aw_beats++; last_awaddr = s_awaddr; end
            if (s_w) begin
                w_got = 1; w_d = s_wdata; w_s = s_wstrb; w_beats++;
                last_wdata = s_wdata; last_wstrb = s_wstrb;
            end
            if (s_b) begin m_bvalid = 0; b_beats++; end
            if (s_ar) begin ar_got = 1; ar_a = s_araddr; ar_beats++; end
            if (s_r) m_rvalid = 0;
            if (aw_got && w_got && !m_bvalid) begin
                if (b_wait >= b_dly) begin
                    smem[aw_a] = merge(smem.exists(aw_a) ? smem[aw_a] : 32'h0, w_d, w_s);
                    m_bvalid = 1; m_bresp = cfg_bresp;
                    aw_got = 0; w_got = 0; b_wait = 0;
                end else b_wait++;
            end
            if (ar_got && !m_rvalid) begin
                m_rvalid = 1; m_rdata = smem.exists(ar_a) ? smem[ar_a] : 32'h0; m_rresp = cfg_rresp;
                ar_got = 0;
            end
            if (m_awvalid && !aw_got) begin m_awready = (aw_seen >= aw_dly); aw_seen++; end
            else begin m_awready = 0; aw_seen = 0; end
            if (m_wvalid && !w_got) begin m_wready = (w_seen >= w_dly); w_seen++; end
            else begin m_wready = 0; w_seen = 0; end
            if (m_arvalid && !ar_got && !ar_block) begin m_arready = (ar_seen >= ar_dly); ar_seen++; end
            else begin m_arready = 0; ar_seen = 0; end
            s_aw = m_awvalid && m_awready; s_awaddr = m_awaddr;
            s_w  = m_wvalid && m_wready;   s_wdata = m_wdata; s_wstrb = m_wstrb;
            s_b  = m_bvalid && m_bready;
            s_ar = m_arvalid && m_arready; s_araddr = m_araddr;
            s_r  = m_rvalid && m_rready;
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    typedef struct packed { logic wr; logic [31:0] rdata; logic [1:0] resp; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] mmem [logic [31:0]];
    bit          busy = 0;
    logic [31:0] e_wr = 0, e_rd = 0, e_err = 0;
    int          since_rel = 0;
    bit          aw_w_split = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [34:0] p_rsp;

    always @(negedge clk_main_a0) begin
        rsp_t e;
        #3;
        if (!rst_main_n) begin
            chk("rst_ctrl_zero", {cmd_ready, rsp_valid, rsp_wr, m_awvalid, m_wvalid, m_bready,
                                  m_arvalid, m_rready, tmo_err}, 0);
            chk("rst_data_zero", |{rsp_rdata, rsp_resp, m_awaddr, m_wdata, m_wstrb, m_araddr}, 0);
            chk("rst_cnt_zero", |{wr_cnt, rd_cnt, err_cnt}, 0);
            exp_q.delete();
            busy = 0; e_wr = 0; e_rd = 0; e_err = 0; since_rel = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0;
        end else begin
            chk("cmd_ready", cmd_ready, !busy && since_rel >= 1);
            chk("wr_cnt", wr_cnt, e_wr);
            chk("rd_cnt", rd_cnt, e_rd);
            chk("err_cnt", err_cnt, e_err);
`ifndef AXIL_MST_TIMEOUT_EN
            chk("tmo_err_off", tmo_err, 0);
`endif
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else chk("rsp_payload", {rsp_wr, rsp_rdata, rsp_resp}, exp_q[0]);
            end
            if (p_awv && !p_awr) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   chk("w_hold", {m_wvalid, m_wdata, m_wstrb}, {1'b1, p_wdata, p_wstrb});
            if (p_arv && !p_arr) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, p_araddr});
            if (p_rv && !p_rr)   chk("rsp_hold", {rsp_valid, rsp_wr, rsp_rdata, rsp_resp}, {1'b1, p_rsp});
            if (m_wvalid && !m_awvalid) aw_w_split = 1;
            // model advances for the coming rising edge
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.wr) e_wr++; else e_rd++;
                if (e.resp != 2'b00) e_err++;
                busy = 0;
            end
            if (cmd_valid && cmd_ready) begin
                busy = 1;
                if (cmd_wr) begin
                    mmem[cmd_addr] = merge(mmem.exists(cmd_addr) ? mmem[cmd_addr] : 32'h0,
                                           cmd_wdata, cmd_wstrb);
                    e = '{wr: 1'b1, rdata: 32'h0, resp: cfg_bresp};
                end else begin
                    e = '{wr: 1'b0, rdata: (mmem.exists(cmd_addr) ? mmem[cmd_addr] : 32'h0),
                          resp: cfg_rresp};
                end
                exp_q.push_back(e);
            end
            since_rel++;
            p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
            p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
            p_rv = rsp_valid; p_rr = rsp_ready; p_rsp = {rsp_wr, rsp_rdata, rsp_resp};
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk_main_a0);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin @(negedge clk_main_a0); n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
        @(negedge clk_main_a0);
        cmd_valid = 0; cmd_wr = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk_main_a0); lat++; end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        int n = 0;
        while (!(rsp_valid && rsp_ready) && n < 100) begin @(negedge clk_main_a0); n++; end
        if (!(rsp_valid && rsp_ready)) chk("rsp_handshake_timeout", rsp_valid, 1);
        @(negedge clk_main_a0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, b0, aw0, w0, n;
        repeat (3) @(negedge clk_main_a0);
        #1 rst_main_n = 1;
        repeat (2) @(negedge clk_main_a0);

        // write 0x500, zero-wait slave
        issue(1, 32'h500, 32'hDEADBEEF, 4'hF);
        wait_rsp(lat);
        chk("t1_latency", lat, 3);
        chk("t1_rsp", {rsp_wr, rsp_rdata, rsp_resp}, {1'b1, 32'h0, 2'b00});
        finish_rsp();
        chk("t1_aw_beats", aw_beats, 1);
        chk("t1_w_beats", w_beats, 1);
        chk("t1_awaddr", last_awaddr, 32'h500);
        chk("t1_wdata", last_wdata, 32'hDEADBEEF);
        chk("t1_wstrb", last_wstrb, 4'hF);
        chk("t1_wr_cnt", wr_cnt, 1);

        // read back
        issue(0, 32'h500, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t2_latency", lat, 3);
        chk("t2_rsp", {rsp_wr, rsp_rdata, rsp_resp}, {1'b0, 32'hDEADBEEF, 2'b00});
        finish_rsp();
        chk("t2_rd_cnt", rd_cnt, 1);

        // partial-strobe merge
        issue(1, 32'h504, 32'h11223344, 4'hF); wait_rsp(lat); finish_rsp();
        issue(1, 32'h504, 32'hAABBCCDD, 4'b0101); wait_rsp(lat); finish_rsp();
        issue(0, 32'h504, 32'h0, 4'h0); wait_rsp(lat);
        chk("strb_merge_rdata", rsp_rdata, 32'h11BB33DD);
        finish_rsp();

        // AW accepted 4 clocks before W
        aw_dly = 0; w_dly = 4; aw_w_split = 0;
        b0 = b_beats; aw0 = aw_beats; w0 = w_beats;
        issue(1, 32'h508, 32'hCAFEF00D, 4'hF); wait_rsp(lat); finish_rsp();
        chk("t3_aw_beats", aw_beats - aw0, 1);
        chk("t3_w_beats", w_beats - w0, 1);
        chk("t3_b_beats", b_beats - b0, 1);
        chk("t3_w_alone", aw_w_split, 1);
        chk("t3_wdata", last_wdata, 32'hCAFEF00D);
        chk("t3_wr_cnt", wr_cnt, 4);
        w_dly = 0;

        // RRESP error with a stalled consumer
        cfg_rresp = 2'b10; rsp_ready = 0;
        issue(0, 32'h500, 32'h0, 4'h0); wait_rsp(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_main_a0);
            chk("t4_cmd_ready_low", cmd_ready, 0);
            chk("t4_rsp_held", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'hDEADBEEF, 2'b10});
        end
        chk("t4_err_before", err_cnt, 0);
        rsp_ready = 1;
        finish_rsp();
        chk("t4_err_after", err_cnt, 1);
        chk("t4_rd_cnt", rd_cnt, 3);
        cfg_rresp = 2'b00;

        // BRESP error
        cfg_bresp = 2'b11;
        issue(1, 32'h50C, 32'h0000FFFF, 4'h3); wait_rsp(lat);
        chk("bresp_err_rsp", {rsp_wr, rsp_resp}, {1'b1, 2'b11});
        finish_rsp();
        chk("bresp_err_cnt", err_cnt, 2);
        cfg_bresp = 2'b00;

        // reset while waiting for B
        b_dly = 1000;
        issue(1, 32'h600, 32'h0BAD0BAD, 4'hF);
        n = 0;
        while (!m_bready && n < 50) begin @(negedge clk_main_a0); n++; end
        chk("t5_in_wr_b", m_bready, 1);
        #2 rst_main_n = 0;
        #1 chk("t5_rst_valids", {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 0);
        chk("t5_rst_cnt", wr_cnt, 0);
        repeat (2) @(negedge clk_main_a0);
        #1 rst_main_n = 1; b_dly = 0;
        repeat (2) @(negedge clk_main_a0);
        chk("t5_idle", cmd_ready, 1);
        chk("t5_no_count", wr_cnt, 0);
        issue(1, 32'h600, 32'h12345678, 4'hF); wait_rsp(lat); finish_rsp();
        issue(0, 32'h600, 32'h0, 4'h0); wait_rsp(lat);
        chk("t5_after_rdata", rsp_rdata, 32'h12345678);
        finish_rsp();
        chk("t5_after_cnts", {wr_cnt, rd_cnt}, {32'd1, 32'd1});

        // AR stalled by the slave
        ar_block = 1;
        issue(0, 32'h500, 32'h0, 4'h0);
`ifdef AXIL_MST_TIMEOUT_EN
        repeat (TMO - 1) @(negedge clk_main_a0);
        chk("t6_tmo_before", tmo_err, 0);
        @(negedge clk_main_a0);
        chk("t6_tmo_rise", tmo_err, 1);
        repeat (5) @(negedge clk_main_a0);
        chk("t6_still_waiting", m_arvalid, 1);
`else
        repeat (40) @(negedge clk_main_a0);
        chk("t6_no_tmo", tmo_err, 0);
        chk("t6_still_waiting", m_arvalid, 1);
`endif
        ar_block = 0;
        wait_rsp(lat);
        chk("t6_rsp", {rsp_wr, rsp_rdata, rsp_resp}, {1'b0, 32'hDEADBEEF, 2'b00});
        finish_rsp();
        chk("t6_rd_cnt", rd_cnt, 2);
`ifdef AXIL_MST_TIMEOUT_EN
        chk("t6_tmo_sticky", tmo_err, 1);
`endif

        repeat (3) @(negedge clk_main_a0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
